mem_responder: RTL

- Memory-side responder for the multicycle datapath. It serves the word read/write requests that the control FSM issues for instruction fetch and load/store.
- It owns a word array with a fixed, parameterised access latency and signals completion with a one-cycle ack.
- It replaces the fixed "wait N cycles" assumption with an explicit req/ack handshake, so the control unit can be driven by a real completion signal.

---
 rtl/mem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-array memory responder with fixed access latency and req/ack handshake.
// Optional misaligned-access detection is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_responder #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   mis_q, mis_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic [31:0] mem [2**ADDR_BITS];

    logic accept;
    logic finish;
    logic mem_wr;
    logic req_mis;
    logic unused_addr_bits;

    assign accept = (state_q == S_IDLE) && req;
    // The access happens on the edge that leaves WAIT, i.e. E_LATENCY.
    assign finish = (state_q == S_WAIT) && (cnt_q == 4'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    assign req_mis = (addr[1:0] != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    // Upper address bits alias; low bits only matter with misalignment checking.
    assign unused_addr_bits = ^{addr[31:ADDR_BITS+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        if (accept) begin
            we_d    = we;
            idx_d   = addr[ADDR_BITS+1:2];
            wdata_d = wdata;
            mis_d   = req_mis;
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
        end else if (state_q == S_WAIT) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                ack_d  = 1'b1;
                busy_d = 1'b0;
                err_d  = mis_q;
                // Read-before-write: a write returns the word's previous contents.
                rdata_d = mis_q ? 32'h0 : mem[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            mis_q   <= 1'b0;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Memory is never cleared; reset only suppresses a pending commit.
    assign mem_wr = finish && we_q && !mis_q && !reset;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
